main_mem_ctrl: RTL

Synthesizable backing-memory controller that sits directly downstream of the processor top level. It consumes the mem_req / mem_req_data channel that the cache subsystem drives and produces the tagged mem_resp beat stream the caches consume. It serves one burst at a time, with byte-masked burst writes and fixed-latency burst reads from an internal beat-wide RAM. It is used as the memory target in simulation and in on-chip builds without DRAM.

---
 rtl/main_mem_ctrl_pkg.sv | 25 ++
 rtl/main_mem_ram.sv | 28 ++
 rtl/main_mem_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/main_mem_ctrl_pkg.sv
// Shared constants and FSM state encoding for main_mem_ctrl and its RAM.
// Supplies fallback values for the MEM_* width macros when no build header provides them.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 8
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 64
`endif

package main_mem_ctrl_pkg;

   localparam int DATA_CYCLES_DEF  = 4;
   localparam int READ_LATENCY_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WDATA = 2'd1,
      RLAT  = 2'd2,
      RDATA = 2'd3
   } state_t;

endpackage

// File: rtl/main_mem_ram.sv
// Byte-masked, synchronous-read single-port RAM, DATA_BITS x 2^DEPTH_LOG2.
// The stored contents have no reset.
module main_mem_ram
   import main_mem_ctrl_pkg::*;
#(
   parameter int DATA_BITS  = `MEM_DATA_BITS,
   parameter int DEPTH_LOG2 = 12
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [DEPTH_LOG2-1:0]   addr,
   input  logic [DATA_BITS-1:0]    wdata,
   input  logic [DATA_BITS/8-1:0]  wmask,
   output logic [DATA_BITS-1:0]    rdata
);

   logic [DATA_BITS-1:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < DATA_BITS/8; i++) begin
            if (wmask[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/main_mem_ctrl.sv
// Single-burst backing-memory controller: masked burst writes, fixed-latency burst reads.
// Define MAIN_MEM_CTRL_STATS_EN to add saturating rd_bursts/wr_bursts/busy_cycles counters.
module main_mem_ctrl
   import main_mem_ctrl_pkg::*;
#(
   parameter int ADDR_BITS    = `MEM_ADDR_BITS,
   parameter int TAG_BITS     = `MEM_TAG_BITS,
   parameter int DATA_BITS    = `MEM_DATA_BITS,
   parameter int DATA_CYCLES  = DATA_CYCLES_DEF,
   parameter int DEPTH_LOG2   = 12,
   parameter int READ_LATENCY = READ_LATENCY_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    mem_req_valid,
   output logic                    mem_req_ready,
   input  logic                    mem_req_rw,
   input  logic [ADDR_BITS-1:0]    mem_req_addr,
   input  logic [TAG_BITS-1:0]     mem_req_tag,
   input  logic                    mem_req_data_valid,
   output logic                    mem_req_data_ready,
   input  logic [DATA_BITS-1:0]    mem_req_data_bits,
   input  logic [DATA_BITS/8-1:0]  mem_req_data_mask,
   output logic                    mem_resp_valid,
   output logic [TAG_BITS-1:0]     mem_resp_tag,
   output logic [DATA_BITS-1:0]    mem_resp_data
`ifdef MAIN_MEM_CTRL_STATS_EN
   ,
   output logic [31:0]             rd_bursts,
   output logic [31:0]             wr_bursts,
   output logic [31:0]             busy_cycles
`endif
);

   localparam int BB = $clog2(DATA_CYCLES);
   localparam int LW = $clog2(READ_LATENCY) + 1;

   state_t                 state, state_nxt;
   logic [BB-1:0]          beat_cnt, beat_cnt_nxt, sel_beat;
   logic [LW-1:0]          lat_cnt, lat_cnt_nxt;
   logic [DEPTH_LOG2-1:0]  base_p0, ram_addr;
   logic [TAG_BITS-1:0]    tag_p0;
   logic [DATA_BITS-1:0]   ram_q;
   logic                   ram_we, last_beat, addr_unused;

   assign addr_unused = ^mem_req_addr;
   assign last_beat   = &beat_cnt;
   assign ram_we      = (state == WDATA) && mem_req_data_valid;
   assign ram_addr    = base_p0 | DEPTH_LOG2'(sel_beat);

   always_comb begin
      state_nxt          = state;
      beat_cnt_nxt       = beat_cnt;
      lat_cnt_nxt        = lat_cnt;
      sel_beat           = '0;
      mem_req_ready      = (state == IDLE) && !reset;
      mem_req_data_ready = (state == WDATA);
      mem_resp_valid     = (state == RDATA);
      mem_resp_tag       = '0;
      mem_resp_data      = '0;
      case (state)
         IDLE: begin
            if (mem_req_valid) begin
               state_nxt    = mem_req_rw ? WDATA : RLAT;
               beat_cnt_nxt = '0;
               lat_cnt_nxt  = '0;
            end
         end
         WDATA: begin
            sel_beat = beat_cnt;
            if (mem_req_data_valid) begin
               beat_cnt_nxt = beat_cnt + 1'b1;
               if (last_beat) state_nxt = IDLE;
            end
         end
         RLAT: begin
            // Final latency cycle presents beat 0 to the RAM so it lands as RDATA begins.
            if (lat_cnt == LW'(READ_LATENCY - 1)) state_nxt = RDATA;
            else lat_cnt_nxt = lat_cnt + 1'b1;
         end
         RDATA: begin
            sel_beat      = beat_cnt + 1'b1;
            beat_cnt_nxt  = beat_cnt + 1'b1;
            mem_resp_tag  = tag_p0;
            mem_resp_data = ram_q;
            if (last_beat) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         beat_cnt <= '0;
         lat_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         beat_cnt <= beat_cnt_nxt;
         lat_cnt  <= lat_cnt_nxt;
      end
   end

   // p0: request capture (burst-aligned, aliased base and tag)
   always_ff @(posedge clk) begin
      if (state == IDLE && mem_req_valid) begin
         base_p0 <= {mem_req_addr[DEPTH_LOG2-1:BB], {BB{1'b0}}};
         tag_p0  <= mem_req_tag;
      end
   end

   main_mem_ram #(
      .DATA_BITS  (DATA_BITS),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (mem_req_data_bits),
      .wmask (mem_req_data_mask),
      .rdata (ram_q)
   );

`ifdef MAIN_MEM_CTRL_STATS_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_bursts   <= '0;
         wr_bursts   <= '0;
         busy_cycles <= '0;
      end else begin
         if (state == RDATA && last_beat) rd_bursts <= sat_inc(rd_bursts);
         if (ram_we && last_beat)         wr_bursts <= sat_inc(wr_bursts);
         if (state != IDLE)               busy_cycles <= sat_inc(busy_cycles);
      end
   end
`endif

endmodule
